// File: rtl/gf180mcu_fd_sc_mcu7t5v0__pwrsw_seq_pkg.sv
// Shared definitions for the power-switch group sequencer: state encoding,
// parameter range limits and the step-counter width helper.
package gf180mcu_fd_sc_mcu7t5v0__pwrsw_seq_pkg;

  localparam int GROUPS_MIN      = 1;
  localparam int GROUPS_MAX      = 16;
  localparam int STEP_CYCLES_MIN = 1;
  localparam int STEP_CYCLES_MAX = 256;

  localparam logic [1:0] ST_OFF       = 2'd0;
  localparam logic [1:0] ST_RAMP_UP   = 2'd1;
  localparam logic [1:0] ST_ON        = 2'd2;
  localparam logic [1:0] ST_RAMP_DOWN = 2'd3;

  typedef enum logic [1:0] {
    S_OFF       = ST_OFF,
    S_RAMP_UP   = ST_RAMP_UP,
    S_ON        = ST_ON,
    S_RAMP_DOWN = ST_RAMP_DOWN
  } pwrsw_state_e;

  // A single-cycle step still needs a 1-bit counter so the timer keeps a
  // uniform structure; it simply never leaves zero.
  function automatic int step_cnt_width(input int step_cycles);
    return (step_cycles > 1) ? $clog2(step_cycles) : 1;
  endfunction

endpackage

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__pwrsw_seq_timer.sv
// Inrush spacing timer: reloads STEP_CYCLES-1 whenever the enables change and
// counts down to zero; a new enable change is allowed only at zero.
module gf180mcu_fd_sc_mcu7t5v0__pwrsw_seq_timer
  import gf180mcu_fd_sc_mcu7t5v0__pwrsw_seq_pkg::*;
#(
  parameter int STEP_CYCLES = 8,
  parameter int CNT_W       = step_cnt_width(STEP_CYCLES)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  output logic allowed
);

  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(STEP_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  // Down-counter: reload on every enable change, otherwise decay to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= RELOAD;
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign allowed = (cnt == '0);

endmodule

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__pwrsw_seq.sv
// Staggered power-switch group enable sequencer.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// OFF       | all groups off, waiting for REQ (and for the step timer)
// RAMP_UP   | turning groups on one by one, lowest first
// ON        | all groups on and settled, ACK asserted
// RAMP_DOWN | turning groups off one by one, highest first
module gf180mcu_fd_sc_mcu7t5v0__pwrsw_seq
  import gf180mcu_fd_sc_mcu7t5v0__pwrsw_seq_pkg::*;
#(
  parameter int GROUPS      = 4,
  parameter int STEP_CYCLES = 8
) (
  input  logic              CLK,
  input  logic              RN,
  input  logic              REQ,
  output logic [GROUPS-1:0] EN,
  output logic              ACK,
  output logic              BUSY
);

  if (GROUPS < GROUPS_MIN || GROUPS > GROUPS_MAX) begin : g_bad_groups
    $error("pwrsw_seq: GROUPS=%0d outside %0d..%0d", GROUPS, GROUPS_MIN, GROUPS_MAX);
  end
  if (STEP_CYCLES < STEP_CYCLES_MIN || STEP_CYCLES > STEP_CYCLES_MAX) begin : g_bad_step
    $error("pwrsw_seq: STEP_CYCLES=%0d outside %0d..%0d", STEP_CYCLES,
           STEP_CYCLES_MIN, STEP_CYCLES_MAX);
  end

  localparam int CNT_W = step_cnt_width(STEP_CYCLES);

  logic [1:0]        state;
  logic [1:0]        state_nx;
  logic [GROUPS-1:0] en;
  logic [GROUPS-1:0] en_nx;
  logic [GROUPS-1:0] en_up;
  logic [GROUPS-1:0] en_dn;
  logic              ack;
  logic              busy;
  logic              step_ok;
  logic              en_load;

  // Thermometer neighbours: one more group on, one fewer group on.
  assign en_up = (en << 1) | GROUPS'(1);
  assign en_dn = en >> 1;

  // Any enable change restarts the spacing timer.
  assign en_load = (en_nx != en);

  gf180mcu_fd_sc_mcu7t5v0__pwrsw_seq_timer #(
    .STEP_CYCLES(STEP_CYCLES),
    .CNT_W      (CNT_W)
  ) u_timer (
    .clk    (CLK),
    .rst_n  (RN),
    .load   (en_load),
    .allowed(step_ok)
  );

  // Next-state and next-enable decision; at most one group moves per edge.
  always_comb begin
    state_nx = state;
    en_nx    = en;
    case (state)
      ST_OFF: begin
        if (REQ && step_ok) begin
          en_nx    = GROUPS'(1);
          state_nx = ST_RAMP_UP;
        end
      end
      ST_RAMP_UP: begin
        if (REQ) begin
          if (step_ok) begin
            if (&en) begin
              state_nx = ST_ON;
            end else begin
              en_nx = en_up;
            end
          end
        end else begin
          state_nx = ST_RAMP_DOWN;
          if (step_ok) begin
            en_nx = en_dn;
            // Dropping the last group while reversing lands directly in OFF
            // so RAMP_DOWN never holds an all-off vector.
            if (en_dn == '0) begin
              state_nx = ST_OFF;
            end
          end
        end
      end
      ST_ON: begin
        // ON is only entered with the timer expired, so no step check here.
        if (!REQ) begin
          en_nx    = en_dn;
          state_nx = (en_dn == '0) ? ST_OFF : ST_RAMP_DOWN;
        end
      end
      ST_RAMP_DOWN: begin
        if (REQ) begin
          state_nx = ST_RAMP_UP;
        end else if (step_ok) begin
          en_nx = en_dn;
          if (en_dn == '0) begin
            state_nx = ST_OFF;
          end
        end
      end
      default: begin
        state_nx = ST_OFF;
        en_nx    = '0;
      end
    endcase
  end

  // State and registered outputs; reset drops every group at once.
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state <= ST_OFF;
      en    <= '0;
      ack   <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= state_nx;
      en    <= en_nx;
      ack   <= (state_nx == ST_ON);
      busy  <= (state_nx == ST_RAMP_UP) || (state_nx == ST_RAMP_DOWN);
    end
  end

  assign EN   = en;
  assign ACK  = ack;
  assign BUSY = busy;

endmodule

// File: doc/gf180mcu_fd_sc_mcu7t5v0__pwrsw_seq.md
GF180MCU_FD_SC_MCU7T5V0__PWRSW_SEQ -- requirements
Module: gf180mcu_fd_sc_mcu7t5v0__pwrsw_seq

Purpose: staggered enable of power-switch groups that feed a switched row of cells, limiting inrush current.

Interface
REQ-001 SHALL have parameter GROUPS, default 4, number of switch groups; legal range 1..16.
REQ-002 SHALL have parameter STEP_CYCLES, default 8, minimum CLK edges between any two EN changes; legal range 1..256.
REQ-003 SHALL have port CLK  input  1  sole clock, rising-edge.
REQ-004 SHALL have port RN  input  1  asynchronous active-low reset.
REQ-005 SHALL have port REQ  input  1  level power-on request, synchronous to CLK.
REQ-006 SHALL have port EN  output  GROUPS  switch-group enables, thermometer-coded from bit 0.
REQ-007 SHALL have port ACK  output  1  all groups on and settled.
REQ-008 SHALL have port BUSY  output  1  ramp in progress.

Function
REQ-009 SHALL implement states OFF, RAMP_UP, ON, RAMP_DOWN; all outputs registered.
REQ-010 SHALL keep a step counter: loads STEP_CYCLES-1 on every EN change and decrements to 0; "step allowed" = counter is 0.
REQ-011 SHALL guarantee at least STEP_CYCLES rising edges between any two EN changes, under any REQ pattern, including direction reversals.
REQ-012 OFF: REQ=1 and step allowed -> set EN[0], go to RAMP_UP; REQ=1 with step not allowed -> stay OFF until allowed.
REQ-013 RAMP_UP, REQ=1: on step allowed, set the lowest cleared EN bit; if EN is already all ones, go to ON with ACK=1 and no EN change.
REQ-014 RAMP_UP, REQ=0: go to RAMP_DOWN at that edge; counter not reloaded; EN unchanged at that edge unless step allowed, in which case the highest set bit clears.
REQ-015 ON, REQ=0: ACK=0, clear the highest EN bit, and go to RAMP_DOWN, all at the same edge.
REQ-016 RAMP_DOWN, REQ=0: on step allowed, clear the highest set EN bit; when the clear makes EN all zeros, go to OFF at that edge.
REQ-017 RAMP_DOWN, REQ=1: go to RAMP_UP; the next bit sets only when step allowed.
REQ-018 EN SHALL always be thermometer-coded, and SHALL change by exactly one bit per change.
REQ-019 ACK=1 only in ON; BUSY=1 exactly in RAMP_UP or RAMP_DOWN.
REQ-020 GROUPS=1: a single EN bit; RAMP_UP reaches ON STEP_CYCLES edges after EN[0] sets.
REQ-021 STEP_CYCLES=1: counter is constantly 0; EN may change on every edge.

Reset
REQ-022 RN=0 SHALL asynchronously force state OFF, EN=0, ACK=0, BUSY=0, counter=0, regardless of the current state.
REQ-023 Reset mid-ramp SHALL drop all groups immediately; inrush spacing is not enforced across reset.
REQ-024 After RN rises, the first edge with REQ=1 SHALL set EN[0].

Structure
REQ-025 Package gf180mcu_fd_sc_mcu7t5v0__pwrsw_seq_pkg SHALL hold the state enum, its 2-bit encoding, and the GROUPS/STEP_CYCLES range limits.
REQ-026 Step counter SHALL be the sub-module gf180mcu_fd_sc_mcu7t5v0__pwrsw_seq_timer, with ports load, allowed and width $clog2(STEP_CYCLES).
REQ-027 Illegal parameter values SHALL cause an elaboration-time error.

Verification
REQ-028 Defaults, REQ rises at edge 0 -> EN=0001@1, 0011@9, 0111@17, 1111@25; ACK=1@33; BUSY=1 from 1 to 32.
REQ-029 Defaults, ON, REQ falls at edge 40 -> ACK=0 and EN=0111@40, 0011@48, 0001@56, 0000@64; OFF and BUSY=0@64.
REQ-030 REQ rises at 0 and falls at 12 (EN=0011) -> EN=0001@17, 0000@25; no EN change at edges 12..16.
REQ-031 REQ falls at 0 from ON and rises at 3 -> EN=0111@0 and 1111@8; ACK=1@16.
REQ-032 RN pulsed low mid-ramp at EN=0111 -> EN=0, ACK=0, BUSY=0 asynchronously; REQ=1 after release -> EN=0001 at the first edge.
REQ-033 A random REQ toggle assertion over 10^5 cycles SHALL hold: EN thermometer, one bit per change, changes >= STEP_CYCLES edges apart; run at GROUPS=1, STEP_CYCLES=1 and at GROUPS=16, STEP_CYCLES=256.
